// File: rtl/mapu_core.sv
// Matrix APU responder: loads two 3x3 matrices row by row, computes A+B or A*B,
// and streams the three result rows out under ready/valid flow control.
module mapu_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic                  i_op,
  output logic                  o_of,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_r0,
  input  logic [DATA_WIDTH-1:0] i_r1,
  input  logic [DATA_WIDTH-1:0] i_r2,
  output logic                  o_rdy,
  input  logic                  i_rdy,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_r0,
  output logic [DATA_WIDTH-1:0] o_r1,
  output logic [DATA_WIDTH-1:0] o_r2
);

  localparam logic [1:0] ST_LOAD_A  = 2'd0;
  localparam logic [1:0] ST_LOAD_B  = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam int FW = 2*DATA_WIDTH + 2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [1:0]            idx;
  logic                  op_mul;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  row_of;
  logic [FW-1:0]         row_full [3];
  logic [DATA_WIDTH-1:0] mat_a [3][3];
  logic [DATA_WIDTH-1:0] mat_b [3][3];
  logic [DATA_WIDTH-1:0] mat_r [3][3];

  assign in_xfer  = i_vld && o_rdy && (state == ST_LOAD_A || state == ST_LOAD_B);
  assign out_xfer = o_vld && i_rdy && (state == ST_DRAIN);

  // Full-precision result row for the row currently being computed.
  always_comb begin
    row_of = 1'b0;
    for (int j = 0; j < 3; j++) begin
      row_full[j] = '0;
      if (op_mul) begin
        for (int k = 0; k < 3; k++)
          row_full[j] = row_full[j] + FW'(mat_a[idx][k]) * FW'(mat_b[k][j]);
      end else begin
        row_full[j] = FW'(mat_a[idx][j]) + FW'(mat_b[idx][j]);
      end
      row_of = row_of | (|row_full[j][FW-1:DATA_WIDTH]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD_A:  if (in_xfer && idx == 2'd2) state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (in_xfer && idx == 2'd2) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (idx == 2'd2) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (out_xfer && idx == 2'd2) state_nxt = ST_LOAD_A;
      default:    state_nxt = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_LOAD_A;
      idx    <= 2'd0;
      op_mul <= 1'b0;
      o_of   <= 1'b0;
      o_rdy  <= 1'b0;
      o_vld  <= 1'b0;
      o_r0   <= '0;
      o_r1   <= '0;
      o_r2   <= '0;
    end else begin
      state <= state_nxt;
      o_rdy <= i_en && (state_nxt == ST_LOAD_A || state_nxt == ST_LOAD_B);

      if (state_nxt != state) begin
        idx <= 2'd0;
      end else begin
        case (state)
          ST_LOAD_A, ST_LOAD_B: if (in_xfer) idx <= idx + 2'd1;
          ST_COMPUTE:           idx <= idx + 2'd1;
          default:              if (out_xfer) idx <= idx + 2'd1;
        endcase
      end

      if (state == ST_LOAD_A && in_xfer && idx == 2'd0) begin
        op_mul <= i_op;
        o_of   <= 1'b0;
      end

      if (state == ST_COMPUTE && row_of)
        o_of <= 1'b1;

      // Row 0 was written two edges earlier, so it can be presented as the last row is computed.
      if (state == ST_COMPUTE && idx == 2'd2) begin
        o_vld <= 1'b1;
        o_r0  <= mat_r[0][0];
        o_r1  <= mat_r[0][1];
        o_r2  <= mat_r[0][2];
      end

      if (out_xfer) begin
        if (idx == 2'd2) begin
          o_vld <= 1'b0;
        end else begin
          o_r0 <= mat_r[idx + 2'd1][0];
          o_r1 <= mat_r[idx + 2'd1][1];
          o_r2 <= mat_r[idx + 2'd1][2];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && state == ST_LOAD_A) begin
      mat_a[idx][0] <= i_r0;
      mat_a[idx][1] <= i_r1;
      mat_a[idx][2] <= i_r2;
    end
    if (in_xfer && state == ST_LOAD_B) begin
      mat_b[idx][0] <= i_r0;
      mat_b[idx][1] <= i_r1;
      mat_b[idx][2] <= i_r2;
    end
    if (state == ST_COMPUTE) begin
      for (int j = 0; j < 3; j++)
        mat_r[idx][j] <= row_full[j][DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mapu_core.sv
// Bench for mapu_core: directed and random matrix operations checked against
// a plain-arithmetic matrix model.
module tb_mapu_core;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_en = 1'b1;
  logic          i_op = 1'b0;
  logic          i_vld = 1'b0;
  logic          i_rdy = 1'b1;
  logic [DW-1:0] i_r0 = '0, i_r1 = '0, i_r2 = '0;
  logic          o_of, o_rdy, o_vld;
  logic [DW-1:0] o_r0, o_r1, o_r2;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mat_a [3][3];
  logic [DW-1:0] mat_b [3][3];
  logic [DW-1:0] exp_r [3][3];
  logic          exp_of;
  logic [DW-1:0] obs_r [3][3];
  logic          obs_of;
  logic          obs_vld_after;
  logic          obs_ok;
  int            obs_lat;

  mapu_core #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_op(i_op), .o_of(o_of),
    .i_vld(i_vld), .i_r0(i_r0), .i_r1(i_r1), .i_r2(i_r2), .o_rdy(o_rdy),
    .i_rdy(i_rdy), .o_vld(o_vld), .o_r0(o_r0), .o_r1(o_r1), .o_r2(o_r2)
  );

  always #5 clk = ~clk;

  // Reference: textbook matrix sum/product in wide arithmetic, then truncate.
  task automatic model_compute(input logic op);
    logic [65:0] acc;
    exp_of = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        if (op) begin
          acc = '0;
          for (int k = 0; k < 3; k++) acc = acc + 66'(mat_a[i][k]) * 66'(mat_b[k][j]);
        end else begin
          acc = 66'(mat_a[i][j]) + 66'(mat_b[i][j]);
        end
        exp_r[i][j] = acc[31:0];
        if (acc >= 66'h1_0000_0000) exp_of = 1'b1;
      end
  endtask

  task automatic set_test1_a();
    mat_a = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
  endtask

  task automatic set_ones_b();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mat_b[i][j] = 32'd1;
  endtask

  task automatic send_row(input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    logic seen;
    logic done;
    done = 1'b0;
    i_vld = 1'b1;
    i_r0 = r0; i_r1 = r1; i_r2 = r2;
    for (int n = 0; n < 100; n++) begin
      seen = o_rdy;
      @(negedge clk);
      if (seen) begin done = 1'b1; break; end
    end
    i_vld = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL send_row_timeout: o_rdy=%0b required 1", o_rdy);
    end
  endtask

  // i_op toggles after A row 0 to show only the row-0 sample matters.
  task automatic send_op(input logic op);
    i_op = op;
    send_row(mat_a[0][0], mat_a[0][1], mat_a[0][2]);
    i_op = ~op;
    for (int r = 1; r < 3; r++) send_row(mat_a[r][0], mat_a[r][1], mat_a[r][2]);
    for (int r = 0; r < 3; r++) send_row(mat_b[r][0], mat_b[r][1], mat_b[r][2]);
    i_op = 1'b0;
  endtask

  task automatic collect(input logic rand_stall);
    logic v;
    logic rd;
    logic got;
    obs_ok = 1'b1;
    obs_lat = 0;
    while (!o_vld && obs_lat < 20) begin @(negedge clk); obs_lat++; end
    for (int r = 0; r < 3; r++) begin
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
        i_rdy = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rd = i_rdy;
        v = o_vld;
        obs_r[r][0] = o_r0; obs_r[r][1] = o_r1; obs_r[r][2] = o_r2;
        @(negedge clk);
        if (v && rd) begin got = 1'b1; break; end
      end
      if (!got) obs_ok = 1'b0;
    end
    i_rdy = 1'b1;
    obs_vld_after = o_vld;
    obs_of = o_of;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_rdy, o_vld, o_of} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got rdy/vld/of=%b required 000", {o_rdy, o_vld, o_of});
    end
    checks++;
    if ({o_r0, o_r1, o_r2} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h required 0", o_r0, o_r1, o_r2);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_rdy: got %b required 1", o_rdy);
    end
  endtask

  task automatic test_add();
    set_test1_a();
    set_ones_b();
    model_compute(1'b0);
    send_op(1'b0);
    collect(1'b0);
    checks++;
    if (!obs_ok || obs_lat != 3) begin
      errors++;
      $display("[TB] FAIL add_latency: got %0d ok=%0b required 3", obs_lat, obs_ok);
    end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_r[i][j] !== exp_r[i][j]) begin
        errors++;
        $display("[TB] FAIL add_r%0d%0d: got %0d required %0d", i, j, obs_r[i][j], exp_r[i][j]);
      end
    end
    checks++;
    if (obs_of !== 1'b0 || obs_vld_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_of_vld: got of=%b vld=%b required 0 0", obs_of, obs_vld_after);
    end
  endtask

  task automatic test_mul();
    set_test1_a();
    mat_b = mat_a;
    model_compute(1'b1);
    send_op(1'b1);
    collect(1'b0);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_r[i][j] !== exp_r[i][j]) begin
        errors++;
        $display("[TB] FAIL mul_sq_r%0d%0d: got %0d required %0d", i, j, obs_r[i][j], exp_r[i][j]);
      end
    end
    checks++;
    if (obs_of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_sq_of: got %b required 0", obs_of);
    end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mat_b[i][j] = (i == j) ? 32'd1 : 32'd0;
    send_op(1'b1);
    collect(1'b0);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_r[i][j] !== mat_a[i][j]) begin
        errors++;
        $display("[TB] FAIL mul_id_r%0d%0d: got %0d required %0d", i, j, obs_r[i][j], mat_a[i][j]);
      end
    end
  endtask

  task automatic test_overflow();
    set_test1_a();
    mat_a[0][0] = 32'hFFFF_FFFF;
    set_ones_b();
    model_compute(1'b0);
    send_op(1'b0);
    collect(1'b0);
    checks++;
    if (obs_r[0][0] !== exp_r[0][0] || obs_of !== exp_of) begin
      errors++;
      $display("[TB] FAIL ovf_add: got r00=%h of=%b required %h %b", obs_r[0][0], obs_of, exp_r[0][0], exp_of);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_of !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_hold: got %b required 1", o_of);
    end
    set_test1_a();
    mat_a[0] = '{32'h1_0000, 32'd0, 32'd0};
    mat_b[0][0] = 32'h1_0000;
    model_compute(1'b1);
    i_op = 1'b1;
    send_row(mat_a[0][0], mat_a[0][1], mat_a[0][2]);
    checks++;
    if (o_of !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b required 0", o_of);
    end
    for (int r = 1; r < 3; r++) send_row(mat_a[r][0], mat_a[r][1], mat_a[r][2]);
    for (int r = 0; r < 3; r++) send_row(mat_b[r][0], mat_b[r][1], mat_b[r][2]);
    i_op = 1'b0;
    collect(1'b0);
    checks++;
    if (obs_of !== exp_of || obs_r[0][0] !== exp_r[0][0]) begin
      errors++;
      $display("[TB] FAIL ovf_mul: got of=%b r00=%h required %b %h", obs_of, obs_r[0][0], exp_of, exp_r[0][0]);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] r0, r1, r2;
    int n;
    set_test1_a();
    set_ones_b();
    model_compute(1'b0);
    send_op(1'b0);
    n = 0;
    while (!o_vld && n < 20) begin @(negedge clk); n++; end
    r0 = o_r0; r1 = o_r1; r2 = o_r2;
    checks++;
    if ({r0, r1, r2} !== {exp_r[0][0], exp_r[0][1], exp_r[0][2]}) begin
      errors++;
      $display("[TB] FAIL bp_row0: got %0d %0d %0d required %0d %0d %0d", r0, r1, r2, exp_r[0][0], exp_r[0][1], exp_r[0][2]);
    end
    @(negedge clk);
    i_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o_vld !== 1'b1 || o_rdy !== 1'b0 || {o_r0, o_r1, o_r2} !== {exp_r[1][0], exp_r[1][1], exp_r[1][2]}) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got vld=%b rdy=%b %0d %0d %0d required 1 0 %0d %0d %0d",
                 c, o_vld, o_rdy, o_r0, o_r1, o_r2, exp_r[1][0], exp_r[1][1], exp_r[1][2]);
      end
    end
    i_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vld !== 1'b1 || {o_r0, o_r1, o_r2} !== {exp_r[2][0], exp_r[2][1], exp_r[2][2]}) begin
      errors++;
      $display("[TB] FAIL bp_row2: got vld=%b %0d %0d %0d required 1 %0d %0d %0d",
               o_vld, o_r0, o_r1, o_r2, exp_r[2][0], exp_r[2][1], exp_r[2][2]);
    end
    @(negedge clk);
    checks++;
    if (o_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_end_vld: got %b required 0", o_vld);
    end
  endtask

  task automatic test_enable();
    set_test1_a();
    set_ones_b();
    model_compute(1'b0);
    i_op = 1'b0;
    send_row(mat_a[0][0], mat_a[0][1], mat_a[0][2]);
    send_row(mat_a[1][0], mat_a[1][1], mat_a[1][2]);
    i_en = 1'b0;
    @(negedge clk);
    i_vld = 1'b1;
    i_r0 = 32'hDEAD_0001; i_r1 = 32'hDEAD_0002; i_r2 = 32'hDEAD_0003;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_rdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL en_rdy%0d: got %b required 0", c, o_rdy);
      end
      @(negedge clk);
    end
    i_en = 1'b1;
    send_row(mat_a[2][0], mat_a[2][1], mat_a[2][2]);
    for (int r = 0; r < 3; r++) send_row(mat_b[r][0], mat_b[r][1], mat_b[r][2]);
    collect(1'b0);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_r[i][j] !== exp_r[i][j]) begin
        errors++;
        $display("[TB] FAIL en_r%0d%0d: got %0d required %0d", i, j, obs_r[i][j], exp_r[i][j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_test1_a();
    mat_a[0][0] = 32'hFFFF_FFFF;
    set_ones_b();
    model_compute(1'b0);
    send_op(1'b0);
    @(negedge clk);
    checks++;
    if (o_of !== exp_of) begin
      errors++;
      $display("[TB] FAIL rstmid_pre_of: got %b required %b", o_of, exp_of);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_rdy, o_vld, o_of} !== 3'b000 || {o_r0, o_r1, o_r2} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got rdy/vld/of=%b data=%h %h %h required all 0",
               {o_rdy, o_vld, o_of}, o_r0, o_r1, o_r2);
    end
    reset_n = 1'b1;
    @(negedge clk);
    set_test1_a();
    model_compute(1'b0);
    send_op(1'b0);
    collect(1'b0);
    checks++;
    if (!obs_ok || obs_lat != 3) begin
      errors++;
      $display("[TB] FAIL rstmid_latency: got %0d ok=%0b required 3", obs_lat, obs_ok);
    end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_r[i][j] !== exp_r[i][j]) begin
        errors++;
        $display("[TB] FAIL rstmid_r%0d%0d: got %0d required %0d", i, j, obs_r[i][j], exp_r[i][j]);
      end
    end
  endtask

  task automatic test_random();
    logic op;
    for (int t = 0; t < 12; t++) begin
      op = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
        mat_a[i][j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
        mat_b[i][j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      end
      model_compute(op);
      send_op(op);
      collect(1'b1);
      checks++;
      if (!obs_ok || obs_lat != 3) begin
        errors++;
        $display("[TB] FAIL rand%0d_latency: got %0d ok=%0b required 3", t, obs_lat, obs_ok);
      end
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
        checks++;
        if (obs_r[i][j] !== exp_r[i][j]) begin
          errors++;
          $display("[TB] FAIL rand%0d_r%0d%0d: got %h required %h", t, i, j, obs_r[i][j], exp_r[i][j]);
        end
      end
      checks++;
      if (obs_of !== exp_of) begin
        errors++;
        $display("[TB] FAIL rand%0d_of: got %b required %b", t, obs_of, exp_of);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_overflow();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
